// File: rtl/apu_frame_counter.sv
// apu_frame_counter: CPU-cycle frame sequencer emitting quarter/half-frame strobes and the frame IRQ
module apu_frame_counter #(
   parameter int unsigned      CNT_W   = 16,
   parameter logic [CNT_W-1:0] Q1_STEP = CNT_W'(7456),
   parameter logic [CNT_W-1:0] Q2_STEP = CNT_W'(14912),
   parameter logic [CNT_W-1:0] Q3_STEP = CNT_W'(22370),
   parameter logic [CNT_W-1:0] P4_LAST = CNT_W'(29829),
   parameter logic [CNT_W-1:0] P5_LAST = CNT_W'(37281),
   parameter logic [CNT_W-1:0] P5_QH   = CNT_W'(37280)
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       cpu_clk_en,
   input  logic       wr_4017,
   input  logic [7:0] wr_data,
   input  logic       rd_4015,
   output logic       quarter_frame,
   output logic       half_frame,
   output logic       frame_irq
);
   logic [CNT_W-1:0] count_q, count_d;
   logic             mode_q, mode_d, inhibit_q, inhibit_d, irq_q, irq_d, parity_q, parity_d;
   logic             pend_q, pend_d, pend_mode_q, pend_mode_d, qf_q, qf_d, hf_q, hf_d;
   logic [2:0]       delay_q, delay_d;
   logic             apply, wr, rd, at_qh, ev_q, ev_h, irq_set, unused_ok;
   assign unused_ok = ^wr_data[5:0];
   always_comb begin
      wr        = cpu_clk_en && wr_4017;
      rd        = cpu_clk_en && rd_4015;
      apply     = cpu_clk_en && pend_q && delay_q == 3'd1;
      at_qh     = mode_q ? count_q == P5_QH : count_q == P4_LAST;
      ev_q      = cpu_clk_en && (count_q == Q1_STEP || count_q == Q2_STEP || count_q == Q3_STEP || at_qh);
      ev_h      = cpu_clk_en && (count_q == Q2_STEP || at_qh);
      irq_set   = cpu_clk_en && !mode_q && !inhibit_q && (count_q == P4_LAST - 1'b1 || count_q == P4_LAST);
      qf_d      = ev_q || (apply && pend_mode_q);
      hf_d      = ev_h || (apply && pend_mode_q);
      parity_d  = parity_q ^ cpu_clk_en;
      count_d   = !cpu_clk_en ? count_q :
                  (apply || count_q == (mode_q ? P5_LAST : P4_LAST)) ? '0 : count_q + 1'b1;
      mode_d    = apply ? pend_mode_q : mode_q;
      inhibit_d = wr ? wr_data[6] : inhibit_q;
      pend_d    = wr || (pend_q && !apply);
      pend_mode_d = wr ? wr_data[7] : pend_mode_q;
      delay_d   = wr ? (parity_q ? 3'd4 : 3'd3) : (cpu_clk_en && pend_q) ? delay_q - 3'd1 : delay_q;
      irq_d     = (wr && wr_data[6]) ? 1'b0 : irq_set ? 1'b1 : rd ? 1'b0 : irq_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         count_q     <= '0;
         mode_q      <= 1'b0;
         inhibit_q   <= 1'b0;
         irq_q       <= 1'b0;
         parity_q    <= 1'b0;
         pend_q      <= 1'b0;
         pend_mode_q <= 1'b0;
         delay_q     <= 3'd0;
         qf_q        <= 1'b0;
         hf_q        <= 1'b0;
      end else begin
         count_q     <= count_d;
         mode_q      <= mode_d;
         inhibit_q   <= inhibit_d;
         irq_q       <= irq_d;
         parity_q    <= parity_d;
         pend_q      <= pend_d;
         pend_mode_q <= pend_mode_d;
         delay_q     <= delay_d;
         qf_q        <= qf_d;
         hf_q        <= hf_d;
      end
   end
   assign quarter_frame = qf_q;
   assign half_frame    = hf_q;
   assign frame_irq     = irq_q;
endmodule

// File: tb/tb_apu_frame_counter.sv
// tb_apu_frame_counter: directed run on full-size sequencer plus random run on a shortened one, scoreboard-checked
module tb_apu_frame_counter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       rstl0, en0, wr0, rd0, rstl1, en1, wr1, rd1;
   logic [7:0] d0, d1;
   logic       qf0, hf0, irq0, qf1, hf1, irq1;
   int checks = 0, errors = 0;
   logic [2:0] sb0[$], sb1[$];
   logic [2:0] exp0, exp1;
   int c_q1[2] = '{7456, 10};
   int c_q2[2] = '{14912, 20};
   int c_q3[2] = '{22370, 30};
   int c_p4[2] = '{29829, 39};
   int c_p5[2] = '{37281, 49};
   int c_qh[2] = '{37280, 48};
   int m_pos[2], m_cyc[2], m_at[2];
   bit m_mode[2], m_inh[2], m_irq[2], m_pend[2], m_pmode[2];
   apu_frame_counter dut_big (
      .clk(clk), .rst_l(rstl0), .cpu_clk_en(en0), .wr_4017(wr0), .wr_data(d0), .rd_4015(rd0),
      .quarter_frame(qf0), .half_frame(hf0), .frame_irq(irq0));
   apu_frame_counter #(.CNT_W(16), .Q1_STEP(16'd10), .Q2_STEP(16'd20), .Q3_STEP(16'd30),
      .P4_LAST(16'd39), .P5_LAST(16'd49), .P5_QH(16'd48)) dut_small (
      .clk(clk), .rst_l(rstl1), .cpu_clk_en(en1), .wr_4017(wr1), .wr_data(d1), .rd_4015(rd1),
      .quarter_frame(qf1), .half_frame(hf1), .frame_irq(irq1));
   // Reference: frame position modulo period, apply scheduled at an absolute CPU-cycle number
   task automatic model(input int k, input logic e, w, r, rl, input logic [7:0] d);
      bit q, h, set;
      int p, qh_pos, len;
      q = 0; h = 0;
      if (!rl) begin
         m_pos[k] = 0; m_cyc[k] = 0; m_at[k] = 0;
         m_mode[k] = 0; m_inh[k] = 0; m_irq[k] = 0; m_pend[k] = 0; m_pmode[k] = 0;
      end else if (e) begin
         p = m_pos[k];
         qh_pos = m_mode[k] ? c_qh[k] : c_p4[k];
         len = m_mode[k] ? c_p5[k] + 1 : c_p4[k] + 1;
         q = p == c_q1[k] || p == c_q2[k] || p == c_q3[k] || p == qh_pos;
         h = p == c_q2[k] || p == qh_pos;
         set = !m_mode[k] && !m_inh[k] && (p == c_p4[k] - 1 || p == c_p4[k]);
         m_pos[k] = (p + 1) % len;
         if (m_pend[k] && m_cyc[k] == m_at[k]) begin
            m_pos[k] = 0; m_mode[k] = m_pmode[k]; m_pend[k] = 0;
            q |= m_pmode[k]; h |= m_pmode[k];
         end
         if (w && d[6]) m_irq[k] = 0;
         else if (set) m_irq[k] = 1;
         else if (r) m_irq[k] = 0;
         if (w) begin
            m_inh[k] = d[6]; m_pend[k] = 1; m_pmode[k] = d[7];
            m_at[k] = m_cyc[k] + ((m_cyc[k] % 2 == 1) ? 4 : 3);
         end
         m_cyc[k]++;
      end
      if (k == 0) sb0.push_back({q, h, m_irq[k]});
      else sb1.push_back({q, h, m_irq[k]});
   endtask
   task automatic tick(input logic e, w, r, rl, input logic [7:0] d);
      @(negedge clk);
      en0 = e; wr0 = w; rd0 = r; rstl0 = rl; d0 = d;
      rstl1 = $urandom_range(0, 2999) != 0;
      en1 = $urandom_range(0, 2) != 0;
      wr1 = $urandom_range(0, 59) == 0;
      rd1 = $urandom_range(0, 29) == 0;
      d1 = 8'($urandom);
      model(0, en0, wr0, rd0, rstl0, d0);
      model(1, en1, wr1, rd1, rstl1, d1);
   endtask
   always @(posedge clk) begin
      #1;
      if (sb0.size() > 0) begin
         exp0 = sb0.pop_front();
         checks++;
         if ({qf0, hf0, irq0} !== exp0) begin
            errors++;
            $display("FAIL big q/h/irq at %0t: got %b expected %b", $time, {qf0, hf0, irq0}, exp0);
         end
      end
      if (sb1.size() > 0) begin
         exp1 = sb1.pop_front();
         checks++;
         if ({qf1, hf1, irq1} !== exp1) begin
            errors++;
            $display("FAIL small q/h/irq at %0t: got %b expected %b", $time, {qf1, hf1, irq1}, exp1);
         end
      end
   end
   initial begin
      repeat (3) tick(1, 1, 1, 0, 8'h80);
      for (int i = 0; i < 29838; i++)
         tick(1, 0, i == 5000 || i == 29828 || i == 29833, 1, 8'h00);
      tick(1, 1, 0, 1, 8'hC0);
      for (int i = 0; i < 37290; i++)
         tick(1, 0, $urandom_range(0, 999) == 0, 1, 8'h00);
      tick(1, 1, 0, 1, 8'h00);
      tick(1, 0, 0, 1, 8'h00);
      tick(1, 0, 0, 1, 8'h00);
      tick(1, 1, 0, 1, 8'h80);
      for (int i = 0; i < 16000; i++)
         tick(i % 2 == 1, i % 2000 == 0, i % 1500 == 0, 1, 8'hC0);
      tick(1, 1, 0, 1, 8'h40);
      tick(1, 0, 0, 1, 8'h00);
      tick(0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 7500; i++)
         tick(1, 0, 0, 1, 8'h00);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/apu_frame_counter.md
# apu_frame_counter

APU frame sequencer: counts CPU cycles and emits the quarter-frame and half-frame clock strobes that drive the envelope/linear-counter and length-counter/sweep stages, plus the frame IRQ. Sits directly upstream of `length_counter` (its `half_frame` strobe is what decrements length counts) and of the envelope and linear counters. Programmed through the $4017 register write; the frame IRQ flag is cleared by a $4015 read.

## Interface
- `Q1_STEP`, 7456, count value producing the first quarter-frame event
- `Q2_STEP`, 14912, count value producing quarter + half event
- `Q3_STEP`, 22370, count value producing the third quarter-frame event
- `P4_LAST`, 29829, last count of 4-step sequence; quarter + half + IRQ event
- `P5_LAST`, 37281, last count of 5-step sequence
- `P5_QH`, 37280, 5-step fourth quarter + half event
- `CNT_W`, 16, cycle counter width; must hold `P5_LAST`

Ports:
- `clk`  in  1  system clock
- `rst_l`  in  1  reset, synchronous, active-low
- `cpu_clk_en`  in  1  one-`clk` strobe per CPU cycle; all sequencing advances only when high
- `wr_4017`  in  1  $4017 write strobe, honoured only when `cpu_clk_en`=1
- `wr_data`  in  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit
- `rd_4015`  in  1  $4015 read strobe, honoured only when `cpu_clk_en`=1
- `quarter_frame`  out  1  one-`clk` pulse per quarter-frame event
- `half_frame`  out  1  one-`clk` pulse per half-frame event
- `frame_irq`  out  1  frame interrupt flag, level

## Operation
- State: `count[CNT_W-1:0]`, `mode`, `inhibit`, `irq_flag`, `parity`, `pend` (valid), `pend_mode`, `delay[2:0]`.
- Every `cpu_clk_en` cycle: `parity` toggles; `count` increments, except at `P4_LAST` (mode 0) or `P5_LAST` (mode 1), where next `count` = 0.
- Event decode on the current `count` during a `cpu_clk_en` cycle:
  - mode 0: `Q1_STEP` Q; `Q2_STEP` Q+H; `Q3_STEP` Q; `P4_LAST-1` IRQ set; `P4_LAST` Q+H+IRQ set.
  - mode 1: `Q1_STEP` Q; `Q2_STEP` Q+H; `Q3_STEP` Q; `P5_QH` Q+H; never sets IRQ.
- IRQ set means `irq_flag` <= 1 only if `inhibit`=0.
- $4017 write: `inhibit` <= bit6 immediately; if bit6=1, `irq_flag` <= 0. `pend` <= 1, `pend_mode` <= bit7, `delay` <= 3 if `parity`=0 else 4.
- Pending apply: each later `cpu_clk_en` decrements `delay`. On the `cpu_clk_en` cycle with `delay`=1: `count` <= 0, `mode` <= `pend_mode`, `pend` <= 0. If `pend_mode`=1, a Q+H event fires on that cycle.
- A new write while `pend`=1 overwrites `pend_mode` and reloads `delay`. It restarts the delay and does not stack.
- `rd_4015`: `irq_flag` <= 0.
- Priority on `irq_flag` within one cycle, highest first: inhibit write with bit6=1 (clear), then IRQ set, then `rd_4015` clear.
- Event coinciding with the pending-apply cycle: the event decoded from the old `count`/`mode` still fires and is ORed with the apply-time Q+H.
- `cpu_clk_en`=0: all state holds and no events fire. Strobes asserted while `cpu_clk_en`=0 are ignored.

## Timing
- Reset (`rst_l`=0 at a `clk` edge) clears every register: `count`=0, `mode`=0, `inhibit`=0, `irq_flag`=0, `parity`=0, `pend`=0. Outputs are 0 from the following cycle.
- Reset mid-frame or mid-pending discards all progress. No pulse is generated by reset.
- `quarter_frame`/`half_frame` are registered. For an event in `cpu_clk_en` cycle N, the pulse is high during cycle N+1, for exactly one `clk`, regardless of `cpu_clk_en` in N+1.
- `frame_irq` = `irq_flag` register output. It rises in the cycle after the setting edge and falls in the cycle after the clearing edge.
- Write-to-apply latency is 3 (even parity) or 4 (odd parity) `cpu_clk_en` cycles after the write cycle.
- Period: mode 0 is `P4_LAST+1` = 29830 CPU cycles; mode 1 is `P5_LAST+1` = 37282.

## Test plan
- Reset, mode 0, `cpu_clk_en`=1 every `clk`: quarter pulses after counts 7456, 14912, 22370, 29829; half pulses after 14912 and 29829. `frame_irq` rises after count 29828. Next quarter pulse follows 7457 cycles after the wrap.
- `frame_irq`=1, then `rd_4015` → `frame_irq`=0 next cycle. Write 0x40 → no IRQ through the next full frame, while Q/H pulses are unchanged.
- Write 0x80 with `parity`=0 → Q+H pulse together 3 `cpu_clk_en` cycles later. Next events at +7456, +14912, +22370, +37280. Period 37282; `frame_irq` stays 0.
- Write 0x00 with `parity`=1 → apply after 4 cycles with no immediate pulse. Second write 0x80 issued 2 cycles into the delay → delay restarts; Q+H fires 3 or 4 cycles after the second write.
- `rd_4015` on the same cycle as count 29828 → `frame_irq` still 1. `cpu_clk_en` toggling every other `clk` → all event positions double in `clk` cycles and each pulse stays 1 `clk` wide.
- `rst_l` low at count 20000 with a write pending → all outputs 0 next cycle. After release, first quarter pulse comes after count 7456 in mode 0.
